// File: rtl/feature_channel_sequencer.sv
// rtl/feature_channel_sequencer.sv - per-channel weight issue and result assembly ahead of vector_multiplication
//
// Accepts one feature vector, walks the weight/bias table one output channel
// per cycle into the multiplier, follows each channel through the multiplier's
// fixed latency with a tag pipe, and collects the returned bytes into
// out_vector.
//
// Ports:
//   clk, reset     : single clock, synchronous active-high reset
//   in_valid/ready : input vector handshake, in_feature is the vector
//   wr_en/addr/... : weight table write port (accepted only when idle)
//   mul_feature/weight/bias : registered operands to the multiplier
//   mul_result     : quantized multiplier output
//   out_valid/ready: output vector handshake, out_vector holds all channels
module feature_channel_sequencer #(
    parameter int INPUT_DIM    = 4,
    parameter int OUTPUT_DIM   = 16,
    parameter int PRECISION    = 8,
    parameter int MULT_LATENCY = 3
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [INPUT_DIM-1:0][PRECISION:0]      in_feature,
    input  logic                                   wr_en,
    input  logic [$clog2(OUTPUT_DIM):0]            wr_addr,
    input  logic [INPUT_DIM-1:0][PRECISION:0]      wr_weights,
    input  logic signed [31:0]                     wr_bias,
    output logic [INPUT_DIM-1:0][PRECISION:0]      mul_feature,
    output logic [INPUT_DIM-1:0][PRECISION:0]      mul_weight,
    output logic signed [31:0]                     mul_bias,
    input  logic [PRECISION-1:0]                   mul_result,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [OUTPUT_DIM-1:0][PRECISION-1:0]   out_vector
);

    localparam int CH_W = (OUTPUT_DIM > 1) ? $clog2(OUTPUT_DIM) : 1;
    localparam int AW   = $clog2(OUTPUT_DIM) + 1;

    typedef logic [INPUT_DIM-1:0][PRECISION:0] vec_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_OUTPUT
    } state_t;

    state_t                               r_state;
    state_t                               w_state_next;
    logic [CH_W-1:0]                      r_ch;
    logic [CH_W-1:0]                      w_ch_next;

    vec_t                                 r_feature;
    vec_t                                 r_mul_weight;
    logic signed [31:0]                   r_mul_bias;

    vec_t                                 r_tbl_w [OUTPUT_DIM];
    logic signed [31:0]                   r_tbl_b [OUTPUT_DIM];

    // Issue stage: shadows the mul_* operand registers.
    logic                                 r_iss_valid;
    logic [CH_W-1:0]                      r_iss_tag;

    // Tag pipe: tracks each issued channel through the multiplier.
    logic                                 r_tag_v [MULT_LATENCY];
    logic [CH_W-1:0]                      r_tag_t [MULT_LATENCY];

    logic [OUTPUT_DIM-1:0][PRECISION-1:0] r_out;

    logic                                 w_accept;
    logic                                 w_wr_ok;
    logic                                 w_last_ch;
    logic                                 w_pipe_busy;

    // A write in IDLE blocks the input handshake for that cycle.
    assign in_ready  = (r_state == ST_IDLE) && !wr_en;
    assign w_accept  = in_valid && in_ready;
    assign w_wr_ok   = wr_en && (r_state == ST_IDLE) && (wr_addr < AW'(OUTPUT_DIM));
    assign w_last_ch = (r_ch == CH_W'(OUTPUT_DIM - 1));

    // The tail entry is captured on the same edge that leaves DRAIN, so only
    // the issue stage and the non-tail stages keep DRAIN waiting.
    always_comb begin
        w_pipe_busy = r_iss_valid;
        for (int i = 0; i < MULT_LATENCY - 1; i++) begin
            w_pipe_busy = w_pipe_busy | r_tag_v[i];
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ch_next    = r_ch;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_ISSUE;
                    w_ch_next    = '0;
                end
            end
            ST_ISSUE: begin
                if (w_last_ch) begin
                    w_state_next = ST_DRAIN;
                end else begin
                    w_ch_next = r_ch + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!w_pipe_busy) begin
                    w_state_next = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ch    <= '0;
        end else begin
            r_state <= w_state_next;
            r_ch    <= w_ch_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_feature <= '0;
        end else if (w_accept) begin
            r_feature <= in_feature;
        end
    end

    // Operands are loaded for the channel that will be current next cycle, so
    // channel c sits on mul_* during the cycle the FSM holds ch=c.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mul_weight <= '0;
            r_mul_bias   <= '0;
            r_iss_valid  <= 1'b0;
            r_iss_tag    <= '0;
        end else if (w_state_next == ST_ISSUE) begin
            r_mul_weight <= r_tbl_w[w_ch_next];
            r_mul_bias   <= r_tbl_b[w_ch_next];
            r_iss_valid  <= 1'b1;
            r_iss_tag    <= w_ch_next;
        end else begin
            r_mul_weight <= '0;
            r_mul_bias   <= '0;
            r_iss_valid  <= 1'b0;
            r_iss_tag    <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < OUTPUT_DIM; i++) begin
                r_tbl_w[i] <= '0;
                r_tbl_b[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_tbl_w[wr_addr[CH_W-1:0]] <= wr_weights;
            r_tbl_b[wr_addr[CH_W-1:0]] <= wr_bias;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MULT_LATENCY; i++) begin
                r_tag_v[i] <= 1'b0;
                r_tag_t[i] <= '0;
            end
        end else begin
            r_tag_v[0] <= r_iss_valid;
            r_tag_t[0] <= r_iss_tag;
            for (int i = 1; i < MULT_LATENCY; i++) begin
                r_tag_v[i] <= r_tag_v[i-1];
                r_tag_t[i] <= r_tag_t[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out <= '0;
        end else if (r_tag_v[MULT_LATENCY-1]) begin
            r_out[r_tag_t[MULT_LATENCY-1]] <= mul_result;
        end
    end

    assign mul_feature = r_feature;
    assign mul_weight  = r_mul_weight;
    assign mul_bias    = r_mul_bias;
    assign out_valid   = (r_state == ST_OUTPUT);
    assign out_vector  = r_out;

endmodule

// File: tb/tb_feature_channel_sequencer.sv
// tb/tb_feature_channel_sequencer.sv - self-checking bench for feature_channel_sequencer
module tb_feature_channel_sequencer;

    localparam int ID = 4;
    localparam int OD = 16;
    localparam int P  = 8;
    localparam int ML = 3;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic [ID-1:0][P:0]     in_feature;
    logic                   wr_en;
    logic [4:0]             wr_addr;
    logic [ID-1:0][P:0]     wr_weights;
    logic signed [31:0]     wr_bias;
    logic [ID-1:0][P:0]     mul_feature;
    logic [ID-1:0][P:0]     mul_weight;
    logic signed [31:0]     mul_bias;
    logic [P-1:0]           mul_result;
    logic                   out_valid;
    logic                   out_ready;
    logic [OD-1:0][P-1:0]   out_vector;

    always #5 clk = ~clk;

    feature_channel_sequencer #(
        .INPUT_DIM(ID), .OUTPUT_DIM(OD), .PRECISION(P), .MULT_LATENCY(ML)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_feature(in_feature),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_weights(wr_weights), .wr_bias(wr_bias),
        .mul_feature(mul_feature), .mul_weight(mul_weight), .mul_bias(mul_bias),
        .mul_result(mul_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_vector(out_vector)
    );

    // Multiplier stand-in: low P bits of dot+bias, valid ML edges after the
    // sampling edge (sampling edge counted as the first).
    logic [P-1:0] m_pipe [ML];

    function automatic logic [P-1:0] mul_fn(input logic [ID-1:0][P:0] f,
                                            input logic [ID-1:0][P:0] w,
                                            input logic signed [31:0] b);
        int acc;
        acc = int'(b);
        for (int i = 0; i < ID; i++) begin
            acc += int'($signed(f[i])) * int'($signed(w[i]));
        end
        return acc[P-1:0];
    endfunction

    always @(posedge clk) begin
        m_pipe[0] <= mul_fn(mul_feature, mul_weight, mul_bias);
        for (int i = 1; i < ML; i++) m_pipe[i] <= m_pipe[i-1];
    end
    assign mul_result = m_pipe[ML-1];

    // Reference model: table contents and expected channel bytes.
    int m_w [OD][ID];
    int m_b [OD];
    int f_m [ID];
    int w_m [ID];
    int exp_v [OD];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int ref_ch(input int c);
        int s;
        s = m_b[c];
        for (int i = 0; i < ID; i++) s += f_m[i] * m_w[c][i];
        return s & 255;
    endfunction

    function automatic logic [ID-1:0][P:0] pack_f();
        logic [ID-1:0][P:0] v;
        for (int i = 0; i < ID; i++) v[i] = (P+1)'(f_m[i]);
        return v;
    endfunction

    function automatic logic [ID-1:0][P:0] pack_row(input int c);
        logic [ID-1:0][P:0] v;
        for (int i = 0; i < ID; i++) v[i] = (P+1)'(m_w[c][i]);
        return v;
    endfunction

    function automatic int rnd9();
        return int'($urandom_range(0, 511)) - 256;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int addr, input int b, input bit taken);
        logic [ID-1:0][P:0] v;
        for (int i = 0; i < ID; i++) v[i] = (P+1)'(w_m[i]);
        wr_en      = 1'b1;
        wr_addr    = 5'(addr);
        wr_weights = v;
        wr_bias    = b;
        #1;
        check("wr_blocks_in_ready", in_ready, 1'b0);
        tick();
        wr_en = 1'b0;
        if (taken) begin
            for (int i = 0; i < ID; i++) m_w[addr][i] = w_m[i];
            m_b[addr] = b;
        end
    endtask

    // Returns just after the handshake edge.
    task automatic hs_send();
        int k;
        in_valid   = 1'b1;
        in_feature = pack_f();
        k = 0;
        #1;
        while (!in_ready && k < 50) begin
            tick();
            #1;
            k++;
        end
        check("hs_in_ready", in_ready, 1'b1);
        for (int c = 0; c < OD; c++) exp_v[c] = ref_ch(c);
        tick();
        in_valid = 1'b0;
    endtask

    // After edge E0+k the design is in cycle E0+k+1; out_valid first appears
    // in cycle E0+OD+ML+1, i.e. k = OD+ML edges past the handshake.
    task automatic wait_out(input int already);
        int n;
        n = 0;
        while (!out_valid && n < 60) begin
            tick();
            n++;
        end
        check("out_latency", n, OD + ML - already);
    endtask

    task automatic check_vec(input string tag);
        for (int c = 0; c < OD; c++)
            check($sformatf("%s_ch%0d", tag, c), out_vector[c], exp_v[c]);
    endtask

    task automatic accept(input int hold);
        for (int h = 0; h < hold; h++) begin
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_in_ready", in_ready, 1'b0);
            tick();
        end
        check_vec("held");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("acc_out_valid", out_valid, 1'b0);
        check("acc_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_feature = '0; wr_en = 1'b0;
        wr_addr = '0; wr_weights = '0; wr_bias = '0; out_ready = 1'b0;
        for (int c = 0; c < OD; c++) begin
            m_b[c] = 0;
            for (int i = 0; i < ID; i++) m_w[c][i] = 0;
        end
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_vector", out_vector == '0, 1'b1);
        check("rst_mul_weight", mul_weight, '0);
        check("rst_mul_bias", mul_bias, '0);
        check("rst_mul_feature", mul_feature, '0);
        tick();

        // Basic: unit weights, bias = channel index.
        for (int c = 0; c < OD; c++) begin
            for (int i = 0; i < ID; i++) w_m[i] = 1;
            do_write(c, c, 1'b1);
        end
        f_m = '{1, 2, 3, 4};
        hs_send();
        wait_out(0);
        check("basic_ch0", out_vector[0], 10);
        check("basic_ch15", out_vector[15], 25);
        check_vec("basic");

        // Backpressure with a pending vector, then it is taken after release.
        f_m = '{3, -2, 7, 1};
        in_valid   = 1'b1;
        in_feature = pack_f();
        accept(5);
        hs_send();
        wait_out(0);
        check_vec("bp2");
        accept(0);

        // Write/input collision in IDLE.
        f_m = '{1, 1, 1, 1};
        in_valid   = 1'b1;
        in_feature = pack_f();
        w_m = '{2, 2, 2, 2};
        do_write(0, 0, 1'b1);
        hs_send();
        wait_out(0);
        check("coll_ch0", out_vector[0], 8);
        check_vec("coll");
        accept(0);

        // Dropped writes: during ISSUE, and out-of-range address in IDLE.
        for (int i = 0; i < ID; i++) f_m[i] = rnd9();
        hs_send();
        tick(); tick();
        for (int i = 0; i < ID; i++) w_m[i] = rnd9();
        do_write(3, int'($urandom), 1'b0);
        wait_out(3);
        check_vec("drop_a");
        accept(0);
        for (int i = 0; i < ID; i++) w_m[i] = rnd9();
        do_write(16, 77, 1'b0);
        hs_send();
        wait_out(0);
        check_vec("drop_b");
        accept(0);

        // Signed operands and 8-bit wrap.
        f_m = '{-1, -1, -1, -1};
        w_m = '{-1, -1, -1, -1};
        do_write(5, 300, 1'b1);
        hs_send();
        wait_out(0);
        check("wrap_ch5", out_vector[5], 48);
        check_vec("wrap");
        accept(1);

        // Randomized tables, features and backpressure.
        for (int t = 0; t < 4; t++) begin
            int nwr;
            nwr = int'($urandom_range(0, 4));
            for (int k = 0; k < nwr; k++) begin
                int a;
                a = int'($urandom_range(0, 20));
                for (int i = 0; i < ID; i++) w_m[i] = rnd9();
                do_write(a, int'($urandom), a < OD);
            end
            for (int i = 0; i < ID; i++) f_m[i] = rnd9();
            hs_send();
            wait_out(0);
            check_vec($sformatf("rnd%0d", t));
            accept(int'($urandom_range(0, 3)));
        end

        // Reset in the middle of ISSUE at ch=7.
        for (int c = 0; c < OD; c++) begin
            for (int i = 0; i < ID; i++) w_m[i] = rnd9();
            w_m[0] = (c % 2 == 0) ? 17 : -9;
            do_write(c, int'($urandom_range(1, 1000)), 1'b1);
        end
        for (int i = 0; i < ID; i++) f_m[i] = rnd9();
        f_m[0] = 3;
        hs_send();
        check("iss_w0", mul_weight, pack_row(0));
        repeat (7) tick();
        check("iss_w7", mul_weight, pack_row(7));
        check("iss_b7", mul_bias, m_b[7]);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_mul_weight", mul_weight, '0);
        check("mid_rst_mul_feature", mul_feature, '0);
        for (int c = 0; c < OD; c++) begin
            m_b[c] = 0;
            for (int i = 0; i < ID; i++) m_w[c][i] = 0;
        end
        for (int k = 0; k < 5; k++) begin
            check("mid_rst_no_stale", out_vector == '0, 1'b1);
            tick();
        end
        f_m = '{5, 5, 5, 5};
        hs_send();
        wait_out(0);
        check_vec("post_rst");
        accept(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
